wallace_mac_accumulator: RTL and testbench

WALLACE_MAC_ACCUMULATOR -- requirements
Module: wallace_mac_accumulator

---
 rtl/wallace_pkg.sv | 15 +
 rtl/wallace_multiplier.sv | 48 ++++
 rtl/wallace_mac_accumulator.sv | 133 +++++++++++++
 tb/tb_wallace_mac_accumulator.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/wallace_pkg.sv
// wallace_pkg: shared types and constants for the Wallace-tree MAC block.
//   state_t : accumulator frame state (ACCUM collecting products, HOLD presenting a sum)
//   OPND_W  : multiplicand / multiplier width
//   PROD_W  : full product width of one OPND_W x OPND_W multiply
package wallace_pkg;

    localparam int OPND_W = 4;
    localparam int PROD_W = 8;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage : wallace_pkg

// File: rtl/wallace_multiplier.sv
// wallace_multiplier: combinational 4x4 unsigned multiplier built as a Wallace tree.
//   a       in  [3:0] multiplicand
//   b       in  [3:0] multiplier
//   product out [7:0] a*b
// Two carry-save layers of full/half adders reduce the 16 partial products to
// two rows, which a single carry-propagate add then combines.
module wallace_multiplier
    import wallace_pkg::*;
(
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic [PROD_W-1:0] product
);

    // pp[i][j] carries weight 2^(i+j)
    logic [OPND_W-1:0] pp [OPND_W];

    always_comb begin
        for (int i = 0; i < OPND_W; i++) begin
            pp[i] = a & {OPND_W{b[i]}};
        end
    end

    // Layer 1 sums (s*) and carries (c*), indexed by source column
    logic s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;
    // Layer 2 sums (t3/u*) and carries (ct3/cu*)
    logic t3, ct3, u4, cu4, u5, cu5, u6, cu6;

    // Layer 1
    assign {c1, s1} = pp[0][1] + pp[1][0];
    assign {c2, s2} = pp[0][2] + pp[1][1] + pp[2][0];
    assign {c3, s3} = pp[0][3] + pp[1][2] + pp[2][1];
    assign {c4, s4} = pp[1][3] + pp[2][2] + pp[3][1];
    assign {c5, s5} = pp[2][3] + pp[3][2];

    // Layer 2: every column is brought down to at most two bits
    assign {ct3, t3} = s3 + pp[3][0] + c2;
    assign {cu4, u4} = s4 + c3;
    assign {cu5, u5} = s5 + c4;
    assign {cu6, u6} = pp[3][3] + c5;

    // Final carry-propagate add of the two remaining rows
    logic [PROD_W-1:0] row_x, row_y;
    assign row_x   = {cu6, u6, u5, u4, t3, s2, s1, pp[0][0]};
    assign row_y   = {1'b0, cu5, cu4, ct3, 1'b0, c1, 1'b0, 1'b0};
    assign product = row_x + row_y;

endmodule : wallace_multiplier

// File: rtl/wallace_mac_accumulator.sv
// wallace_mac_accumulator: sums FRAME_LEN products a*b per frame and presents
// the frame sum on a valid/ready output.
//   clk, rst_n         clock, asynchronous active-low reset
//   clr                synchronous frame abort (overrides everything else)
//   a, b, in_valid     input beat; in_ready tells when a beat is taken
//   out_data/out_valid completed frame sum; out_ready from consumer
//   ovf                frame sum exceeded 2^ACC_W-1 (valid with out_valid)
// Optional build macro WALLACE_MAC_SAT_EN: the accumulator saturates at
// 2^ACC_W-1 on overflow instead of wrapping. ovf is the same in both builds.
// Pipeline: acceptance edge registers the product, next edge accumulates it.
module wallace_mac_accumulator
    import wallace_pkg::*;
#(
    parameter int FRAME_LEN = 4,
    parameter int ACC_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic [3:0]        a,
    input  logic [3:0]        b,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              ovf
);

    localparam int                CNT_W     = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0]  FRAME_CNT = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    state_t             state_q, state_d;
    logic [PROD_W-1:0]  product;
    logic [PROD_W-1:0]  prod_q;
    logic               prod_vld;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   in_cnt;
    logic [CNT_W-1:0]   acc_cnt;

    logic               accept;
    logic               frame_done;
    logic               out_fire;
    logic [ACC_W:0]     acc_sum;
    logic [ACC_W-1:0]   acc_next;

    wallace_multiplier u_mult (
        .a       (a),
        .b       (b),
        .product (product)
    );

    // Gated by rst_n so nothing is offered while reset is held.
    assign in_ready   = rst_n && (state_q == ACCUM) && (in_cnt < FRAME_CNT);
    assign accept     = in_valid && in_ready;
    assign frame_done = prod_vld && (acc_cnt == LAST_CNT);
    assign out_valid  = (state_q == HOLD);
    assign out_fire   = out_valid && out_ready;
    assign out_data   = acc;

    // One extra bit captures the true sum so overflow is visible.
    assign acc_sum = {1'b0, acc} + (ACC_W + 1)'(prod_q);

`ifdef WALLACE_MAC_SAT_EN
    // Once saturated, any later add overflows again (or adds zero), so acc stays at max.
    assign acc_next = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
`else
    assign acc_next = acc_sum[ACC_W-1:0];
`endif

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ACCUM;
        end else begin
            case (state_q)
                ACCUM:   if (frame_done) state_d = HOLD;
                HOLD:    if (out_ready)  state_d = ACCUM;
                default: state_d = ACCUM;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q   <= '0;
            prod_vld <= 1'b0;
            acc      <= '0;
            in_cnt   <= '0;
            acc_cnt  <= '0;
            ovf      <= 1'b0;
        end else if (clr) begin
            prod_vld <= 1'b0;
            acc      <= '0;
            in_cnt   <= '0;
            acc_cnt  <= '0;
            ovf      <= 1'b0;
        end else if (out_fire) begin
            // Consumer took the frame: start the next one from zero.
            prod_vld <= 1'b0;
            acc      <= '0;
            in_cnt   <= '0;
            acc_cnt  <= '0;
            ovf      <= 1'b0;
        end else begin
            prod_vld <= accept;
            if (accept) begin
                prod_q <= product;
                in_cnt <= in_cnt + CNT_ONE;
            end
            if (prod_vld) begin
                acc     <= acc_next;
                acc_cnt <= acc_cnt + CNT_ONE;
                if (acc_sum[ACC_W]) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

endmodule : wallace_mac_accumulator

// File: tb/tb_wallace_mac_accumulator.sv
// Testbench for wallace_mac_accumulator. Two instances: the default build
// (FRAME_LEN=4, ACC_W=16) and a narrow one (FRAME_LEN=2, ACC_W=8) for overflow.
// Expected frame results are pushed into per-instance queues when stimulus is
// issued; monitors pop and compare whenever an output handshake is presented.
module tb_wallace_mac_accumulator;

    localparam int LIMIT = 200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // Instance 1 (defaults)
    logic        clr1 = 1'b0;
    logic [3:0]  a1 = '0, b1 = '0;
    logic        in_valid1 = 1'b0;
    logic        in_ready1;
    logic [15:0] out_data1;
    logic        out_valid1;
    logic        out_ready1 = 1'b1;
    logic        ovf1;

    // Instance 2 (ACC_W=8, FRAME_LEN=2)
    logic        clr2 = 1'b0;
    logic [3:0]  a2 = '0, b2 = '0;
    logic        in_valid2 = 1'b0;
    logic        in_ready2;
    logic [7:0]  out_data2;
    logic        out_valid2;
    logic        out_ready2 = 1'b1;
    logic        ovf2;

    int checks = 0;
    int errors = 0;

    logic [16:0] exp_q1 [$];   // {ovf, data}
    logic [8:0]  exp_q2 [$];   // {ovf, data}

    always #5 clk = ~clk;

    wallace_mac_accumulator #(.FRAME_LEN(4), .ACC_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr1), .a(a1), .b(b1),
        .in_valid(in_valid1), .in_ready(in_ready1), .out_data(out_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .ovf(ovf1)
    );

    wallace_mac_accumulator #(.FRAME_LEN(2), .ACC_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .clr(clr2), .a(a2), .b(b2),
        .in_valid(in_valid2), .in_ready(in_ready2), .out_data(out_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .ovf(ovf2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: compare whenever a frame is handed over
    always @(negedge clk) begin
        if (rst_n && out_valid1 && out_ready1) begin
            if (exp_q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1_unexpected_frame: got data=0x%0h ovf=%0b, expected no frame", out_data1, ovf1);
            end else begin
                logic [16:0] e;
                e = exp_q1.pop_front();
                check("dut1_frame_data", 32'(out_data1), 32'(e[15:0]));
                check("dut1_frame_ovf", 32'(ovf1), 32'(e[16]));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid2 && out_ready2) begin
            if (exp_q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut2_unexpected_frame: got data=0x%0h ovf=%0b, expected no frame", out_data2, ovf2);
            end else begin
                logic [8:0] e;
                e = exp_q2.pop_front();
                check("dut2_frame_data", 32'(out_data2), 32'(e[7:0]));
                check("dut2_frame_ovf", 32'(ovf2), 32'(e[8]));
            end
        end
    end

    // Present a beat and hold it until the DUT takes it on a rising edge.
    task automatic send1(input logic [3:0] av, input logic [3:0] bv);
        int n = 0;
        @(negedge clk);
        a1 = av; b1 = bv; in_valid1 = 1'b1;
        while (!in_ready1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) check("dut1_in_ready_timeout", 32'(in_ready1), 32'd1);
        @(posedge clk);
        #1 in_valid1 = 1'b0;
    endtask

    task automatic send2(input logic [3:0] av, input logic [3:0] bv);
        int n = 0;
        @(negedge clk);
        a2 = av; b2 = bv; in_valid2 = 1'b1;
        while (!in_ready2 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) check("dut2_in_ready_timeout", 32'(in_ready2), 32'd1);
        @(posedge clk);
        #1 in_valid2 = 1'b0;
    endtask

    // Wait (bounded) until dut1 presents out_valid; returns at a falling edge.
    task automatic wait_out1();
        int n = 0;
        while (!out_valid1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) check("dut1_out_valid_timeout", 32'(out_valid1), 32'd1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q1.size() != 0 || exp_q2.size() != 0) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(exp_q1.size() + exp_q2.size()), 32'd0);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_out_valid", 32'(out_valid1), 32'd0);
        check("rst_out_data", 32'(out_data1), 32'd0);
        check("rst_ovf", 32'(ovf1), 32'd0);
        check("rst_in_ready", 32'(in_ready1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", 32'(in_ready1), 32'd1);

        // Back-to-back frame: 15+225+54+0 = 294
        out_ready1 = 1'b1;
        exp_q1.push_back({1'b0, 16'h0126});
        send1(4'd3, 4'd5); send1(4'd15, 4'd15); send1(4'd9, 4'd6); send1(4'd0, 4'd10);
        wait_out1();
        @(negedge clk);
        check("out_valid_one_cycle", 32'(out_valid1), 32'd0);

        // Same frame, consumer stalls 5 cycles in HOLD
        out_ready1 = 1'b0;
        exp_q1.push_back({1'b0, 16'h0126});
        send1(4'd3, 4'd5); send1(4'd15, 4'd15); send1(4'd9, 4'd6); send1(4'd0, 4'd10);
        wait_out1();
        for (int i = 0; i < 5; i++) begin
            check("hold_out_data", 32'(out_data1), 32'h0126);
            check("hold_out_valid", 32'(out_valid1), 32'd1);
            check("hold_in_ready", 32'(in_ready1), 32'd0);
            if (i < 4) @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready1 = 1'b1;
        @(negedge clk);   // monitor takes the frame here
        @(negedge clk);
        check("after_accept_in_ready", 32'(in_ready1), 32'd1);
        check("after_accept_out_valid", 32'(out_valid1), 32'd0);

        // Gapped input: 1+4+9+16 = 30
        exp_q1.push_back({1'b0, 16'd30});
        send1(4'd1, 4'd1); @(posedge clk);
        send1(4'd2, 4'd2); @(posedge clk);
        send1(4'd3, 4'd3); @(posedge clk);
        @(negedge clk);
        check("gap_no_early_output", 32'(out_valid1), 32'd0);
        send1(4'd4, 4'd4);
        drain("gap_frame_drained");

        // clr after two beats, then (3,5)x4 = 60
        send1(4'd7, 4'd7); send1(4'd9, 4'd9);
        clr1 = 1'b1;
        @(posedge clk);
        #1 clr1 = 1'b0;
        exp_q1.push_back({1'b0, 16'd60});
        for (int i = 0; i < 4; i++) send1(4'd3, 4'd5);
        drain("clr_frame_drained");

        // Narrow instance: 225+225 = 450 overflows 8 bits
`ifdef WALLACE_MAC_SAT_EN
        exp_q2.push_back({1'b1, 8'hFF});
`else
        exp_q2.push_back({1'b1, 8'hC2});
`endif
        send2(4'd15, 4'd15); send2(4'd15, 4'd15);
        // Next frame starts clean: 1+6 = 7, ovf cleared
        exp_q2.push_back({1'b0, 8'd7});
        send2(4'd1, 4'd1); send2(4'd2, 4'd3);
        drain("ovf_frames_drained");

        // Async reset while holding a frame (2*3 x4 = 24)
        out_ready1 = 1'b0;
        for (int i = 0; i < 4; i++) send1(4'd2, 4'd3);
        wait_out1();
        check("pre_rst_hold_valid", 32'(out_valid1), 32'd1);
        check("pre_rst_hold_data", 32'(out_data1), 32'd24);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid1), 32'd0);
        check("async_rst_out_data", 32'(out_data1), 32'd0);
        check("async_rst_ovf", 32'(ovf1), 32'd0);
        check("async_rst_in_ready", 32'(in_ready1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready1 = 1'b1;
        // Fresh frame after reset: 2*4 = 8, nothing left over from the held 24
        exp_q1.push_back({1'b0, 16'd8});
        for (int i = 0; i < 4; i++) send1(4'd1, 4'd2);
        drain("post_rst_frame_drained");

        repeat (4) @(negedge clk);
        check("no_extra_frames", 32'(exp_q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_wallace_mac_accumulator
